// File: rtl/i2c_cfg_pkg.sv
// ---------------------------------------------------------------------------
// i2c_cfg_pkg
// Shared definitions for the I2C configuration path: arbiter state
// encodings, default controller word geometry, timeout defaults and the
// default slave address used by the configuration sequencers.
// No ports (package).
// ---------------------------------------------------------------------------
package i2c_cfg_pkg;

    // Controller word is {slave_addr[7:0], reg_addr[7:0], reg_data[7:0]}
    localparam int DEFAULT_DATA_WIDTH     = 24;
    // 2000 cycles of clk_200kHz = 10 ms
    localparam int DEFAULT_TIMEOUT_CYCLES = 2000;
    localparam int DEFAULT_CNT_WIDTH      = 12;

    // 8-bit write address of the HDMI transmitter (0x72)
    localparam logic [7:0] DEFAULT_SLAVE_ADDR = 8'h72;

    // Arbiter FSM encodings
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GRANT    = 3'd1;
    localparam logic [2:0] ST_START    = 3'd2;
    localparam logic [2:0] ST_WAIT_END = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;

    // True for the states in which a requester owns the controller
    function automatic logic is_owned_state(input logic [2:0] st);
        return (st == ST_GRANT) || (st == ST_START) ||
               (st == ST_WAIT_END) || (st == ST_STOP);
    endfunction

endpackage

// File: rtl/i2c_rr_picker.sv
// ---------------------------------------------------------------------------
// i2c_rr_picker
// Combinational round-robin winner selection. Scans requesters starting
// one past the last served index, wrapping modulo N_REQ.
// Ports:
//   req       in  N_REQ  request vector
//   last_idx  in  IDX_W  index served most recently
//   valid     out 1      at least one request present
//   winner    out IDX_W  first asserted request after last_idx
// ---------------------------------------------------------------------------
module i2c_rr_picker
    import i2c_cfg_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    always_comb begin
        int cand;
        valid  = 1'b0;
        winner = '0;
        cand   = 0;
        // k = N_REQ wraps back to last_idx itself, so a lone requester that
        // was just served can still win.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_idx) + k) % N_REQ;
            if (!valid && req[IDX_W'(cand)]) begin
                valid  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
// Shares one I2C controller among N_REQ configuration sequencers with
// round-robin priority, one 3-byte transaction per grant. Sequences the
// controller start/stop handshake for the winner and aborts a transaction
// that does not end within TIMEOUT_CYCLES.
// All outputs are decoded from registered state only.
// Ports:
//   clk_200kHz        in   1                  clock
//   RESET_CONFIG      in   1                  async reset, active-high
//   REQ               in   N_REQ              per-requester request (level)
//   REQ_DATA          in   N_REQ*DATA_WIDTH   flattened request words
//   GNT               out  N_REQ              one-hot grant (GRANT..STOP)
//   DONE              out  N_REQ              one-cycle completion pulse
//   TIMEOUT_PULSE     out  1                  pulse with DONE on timeout
//   TIMEOUT_FLAG      out  1                  sticky timeout indicator
//   ARB_BUSY          out  1                  state is not IDLE
//   CTRL_READY        in   1                  controller ready
//   CTRL_END          in   1                  controller transaction end
//   CTRL_CONFIG_DATA  out  DATA_WIDTH         word to the controller
//   CTRL_START        out  1                  start strobe
//   CTRL_STOP         out  1                  stop strobe
// CNT_WIDTH must satisfy 2**CNT_WIDTH > TIMEOUT_CYCLES.
// ---------------------------------------------------------------------------
module i2c_bus_arbiter
    import i2c_cfg_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
    input  logic                        clk_200kHz,
    input  logic                        RESET_CONFIG,
    input  logic [N_REQ-1:0]            REQ,
    input  logic [N_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [N_REQ-1:0]            GNT,
    output logic [N_REQ-1:0]            DONE,
    output logic                        TIMEOUT_PULSE,
    output logic                        TIMEOUT_FLAG,
    output logic                        ARB_BUSY,
    input  logic                        CTRL_READY,
    input  logic                        CTRL_END,
    output logic [DATA_WIDTH-1:0]       CTRL_CONFIG_DATA,
    output logic                        CTRL_START,
    output logic                        CTRL_STOP
);

    localparam int                   IDX_W    = $clog2(N_REQ);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      last_idx_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  to_bit_q;
    logic                  timeout_flag_q;

    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic [DATA_WIDTH-1:0] pick_word;
    logic [N_REQ-1:0]      idx_onehot;

    i2c_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req      (REQ),
        .last_idx (last_idx_q),
        .valid    (pick_valid),
        .winner   (pick_idx)
    );

    // Mux the winner's slice out of the flattened request bus
    always_comb begin
        pick_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_word = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_200kHz or posedge RESET_CONFIG) begin
        if (RESET_CONFIG) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            last_idx_q     <= IDX_W'(N_REQ - 1);
            data_q         <= '0;
            cnt_q          <= '0;
            to_bit_q       <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Word is captured here so the requester may change
                    // REQ_DATA as soon as it sees GNT.
                    if (CTRL_READY && pick_valid) begin
                        idx_q   <= pick_idx;
                        data_q  <= pick_word;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    state_q <= ST_START;
                end
                ST_START: begin
                    cnt_q    <= '0;
                    to_bit_q <= 1'b0;
                    state_q  <= ST_WAIT_END;
                end
                ST_WAIT_END: begin
                    // END wins over a coincident timeout
                    if (CTRL_END) begin
                        state_q <= ST_STOP;
                    end else if (cnt_q == CNT_LAST) begin
                        to_bit_q <= 1'b1;
                        state_q  <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    timeout_flag_q <= timeout_flag_q | to_bit_q;
                    last_idx_q     <= idx_q;
                    state_q        <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            idx_onehot[i] = (idx_q == IDX_W'(i));
        end
    end

    // Moore output decode; illegal encodings fall through with all strobes low
    always_comb begin
        GNT              = '0;
        DONE             = '0;
        TIMEOUT_PULSE    = 1'b0;
        CTRL_CONFIG_DATA = '0;
        CTRL_START       = 1'b0;
        CTRL_STOP        = 1'b0;
        ARB_BUSY         = (state_q != ST_IDLE);
        // The flag rises together with the pulse rather than a cycle later
        TIMEOUT_FLAG     = timeout_flag_q | ((state_q == ST_STOP) & to_bit_q);

        if (is_owned_state(state_q)) begin
            GNT              = idx_onehot;
            CTRL_CONFIG_DATA = data_q;
        end
        if (state_q == ST_START) begin
            CTRL_START = 1'b1;
        end
        if (state_q == ST_STOP) begin
            CTRL_STOP     = 1'b1;
            DONE          = idx_onehot;
            TIMEOUT_PULSE = to_bit_q;
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_arbiter
// Directed bench for i2c_bus_arbiter with N_REQ=2, DATA_WIDTH=24,
// TIMEOUT_CYCLES=2000. Inputs change 1 time unit after the rising edge;
// outputs are checked in that same window, so after each tick() the
// outputs show the state entered at the preceding edge.
// ---------------------------------------------------------------------------
module tb_i2c_bus_arbiter;
    import i2c_cfg_pkg::*;

    localparam logic [23:0] W0  = {DEFAULT_SLAVE_ADDR, 16'h0218}; // 0x720218
    localparam logic [23:0] W1  = 24'h341E05;
    localparam logic [23:0] WX  = 24'hABCDEF;

    logic        clk_200kHz = 1'b0;
    logic        RESET_CONFIG;
    logic [1:0]  REQ;
    logic [47:0] REQ_DATA;
    logic [1:0]  GNT;
    logic [1:0]  DONE;
    logic        TIMEOUT_PULSE;
    logic        TIMEOUT_FLAG;
    logic        ARB_BUSY;
    logic        CTRL_READY;
    logic        CTRL_END;
    logic [23:0] CTRL_CONFIG_DATA;
    logic        CTRL_START;
    logic        CTRL_STOP;

    int checks = 0;
    int errors = 0;

    i2c_bus_arbiter #(
        .N_REQ          (2),
        .DATA_WIDTH     (24),
        .TIMEOUT_CYCLES (2000),
        .CNT_WIDTH      (12)
    ) dut (
        .clk_200kHz       (clk_200kHz),
        .RESET_CONFIG     (RESET_CONFIG),
        .REQ              (REQ),
        .REQ_DATA         (REQ_DATA),
        .GNT              (GNT),
        .DONE             (DONE),
        .TIMEOUT_PULSE    (TIMEOUT_PULSE),
        .TIMEOUT_FLAG     (TIMEOUT_FLAG),
        .ARB_BUSY         (ARB_BUSY),
        .CTRL_READY       (CTRL_READY),
        .CTRL_END         (CTRL_END),
        .CTRL_CONFIG_DATA (CTRL_CONFIG_DATA),
        .CTRL_START       (CTRL_START),
        .CTRL_STOP        (CTRL_STOP)
    );

    always #5 clk_200kHz = ~clk_200kHz;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_200kHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input logic [1:0] gnt, input logic [1:0] done,
                               input logic start, input logic stop, input logic busy,
                               input logic pulse, input logic [23:0] data);
        chk({tag, "_gnt"},   32'(GNT),              32'(gnt));
        chk({tag, "_done"},  32'(DONE),             32'(done));
        chk({tag, "_start"}, 32'(CTRL_START),       32'(start));
        chk({tag, "_stop"},  32'(CTRL_STOP),        32'(stop));
        chk({tag, "_busy"},  32'(ARB_BUSY),         32'(busy));
        chk({tag, "_tpls"},  32'(TIMEOUT_PULSE),    32'(pulse));
        chk({tag, "_data"},  32'(CTRL_CONFIG_DATA), 32'(data));
    endtask

    // One round-robin transaction with REQ left high: GRANT, START, END
    // presented 5 cycles after START, STOP, back to IDLE.
    task automatic rr_txn(input string tag, input logic [1:0] gnt, input logic [23:0] data);
        tick();
        expect_outs({tag, "_grant"}, gnt, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, data);
        tick();
        expect_outs({tag, "_start"}, gnt, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, data);
        repeat (5) tick();
        CTRL_END = 1'b1;
        tick();
        CTRL_END = 1'b0;
        expect_outs({tag, "_stop"}, gnt, gnt, 1'b0, 1'b1, 1'b1, 1'b0, data);
        tick();
        expect_outs({tag, "_idle"}, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        RESET_CONFIG = 1'b1;
        REQ          = 2'b00;
        REQ_DATA     = {W1, W0};
        CTRL_READY   = 1'b0;
        CTRL_END     = 1'b0;
        #2;
        expect_outs("rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("rst_flag", 32'(TIMEOUT_FLAG), 32'd0);
        tick();
        tick();
        RESET_CONFIG = 1'b0;

        // Single request; cycle 0 is the edge that samples REQ
        REQ        = 2'b01;
        CTRL_READY = 1'b1;
        tick();                                   // cycle 1
        expect_outs("single_grant", 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, W0);
        REQ = 2'b00;
        tick();                                   // cycle 2
        expect_outs("single_start", 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, W0);
        repeat (8) tick();                        // cycle 10
        expect_outs("single_wait", 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, W0);
        CTRL_END = 1'b1;
        tick();                                   // cycle 11
        CTRL_END = 1'b0;
        expect_outs("single_stop", 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, W0);
        tick();                                   // cycle 12
        expect_outs("single_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

        // Round-robin from a fresh reset: order 0,1,0,1
        RESET_CONFIG = 1'b1;
        tick();
        RESET_CONFIG = 1'b0;
        REQ = 2'b11;
        rr_txn("rr0", 2'b01, W0);
        rr_txn("rr1", 2'b10, W1);
        rr_txn("rr2", 2'b01, W0);
        rr_txn("rr3", 2'b10, W1);
        REQ = 2'b00;

        // Timeout: START at cycle S, WAIT_END holds S+1..S+2000, STOP at S+2001
        REQ = 2'b10;
        tick();
        expect_outs("to_grant", 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, W1);
        REQ = 2'b00;
        tick();
        chk("to_start", 32'(CTRL_START), 32'd1);
        repeat (2000) tick();
        expect_outs("to_last_wait", 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, W1);
        chk("to_flag_before", 32'(TIMEOUT_FLAG), 32'd0);
        tick();
        expect_outs("to_stop", 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, W1);
        chk("to_flag_stop", 32'(TIMEOUT_FLAG), 32'd1);
        tick();
        expect_outs("to_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        repeat (3) tick();
        chk("to_flag_sticky", 32'(TIMEOUT_FLAG), 32'd1);

        // Boundary: END present while the counter sits at 1999 -> success
        REQ = 2'b01;
        tick();
        expect_outs("bnd_grant", 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, W0);
        REQ = 2'b00;
        tick();
        chk("bnd_start", 32'(CTRL_START), 32'd1);
        repeat (2000) tick();
        CTRL_END = 1'b1;
        tick();
        CTRL_END = 1'b0;
        expect_outs("bnd_stop", 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, W0);
        chk("bnd_flag_kept", 32'(TIMEOUT_FLAG), 32'd1);
        tick();
        chk("bnd_idle_busy", 32'(ARB_BUSY), 32'd0);

        // Stability: word changes, REQ drops and a stray END appear after GNT
        REQ = 2'b01;
        tick();
        expect_outs("stab_grant", 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, W0);
        REQ_DATA = {W1, WX};
        REQ      = 2'b00;
        CTRL_END = 1'b1;
        tick();
        CTRL_END = 1'b0;
        expect_outs("stab_start", 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, W0);
        repeat (3) tick();
        expect_outs("stab_wait", 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, W0);
        CTRL_END = 1'b1;
        tick();
        CTRL_END = 1'b0;
        expect_outs("stab_stop", 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, W0);
        tick();
        chk("stab_idle_busy", 32'(ARB_BUSY), 32'd0);

        // READY low blocks grants even with both requesting
        REQ_DATA   = {W1, W0};
        REQ        = 2'b11;
        CTRL_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nrdy_gnt", 32'(GNT), 32'd0);
            chk("nrdy_busy", 32'(ARB_BUSY), 32'd0);
        end
        CTRL_READY = 1'b1;
        tick();
        expect_outs("rdy_grant", 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, W1);
        tick();
        chk("rdy_start", 32'(CTRL_START), 32'd1);
        repeat (3) tick();
        chk("rdy_wait_busy", 32'(ARB_BUSY), 32'd1);

        // Reset mid-WAIT_END: outputs clear without a clock edge, no DONE
        #2;
        RESET_CONFIG = 1'b1;
        #1;
        expect_outs("mid_rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("mid_rst_flag", 32'(TIMEOUT_FLAG), 32'd0);
        tick();
        chk("mid_rst_done", 32'(DONE), 32'd0);
        RESET_CONFIG = 1'b0;
        tick();
        expect_outs("post_rst_grant", 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, W0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
